// File: rtl/qed_pkg.sv
// Constants shared by the QED duplicator and consistency checker:
// error codes, checker FSM encoding and the original-to-duplicate rd offset.
package qed_pkg;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_DATA    = 3'd1;
  localparam logic [2:0] ERR_RD      = 3'd2;
  localparam logic [2:0] ERR_ORPHAN  = 3'd3;
  localparam logic [2:0] ERR_OVF     = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT = 3'd5;

  localparam int unsigned DUP_OFFSET = 16;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_FAIL = 1'b1
  } state_e;

endpackage

// File: rtl/qed_wb_fifo.sv
// In-order buffer of original writebacks {rd, data}; at most one push or pop per cycle.
module qed_wb_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 37
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push_s, do_pop_s;

  assign full_o    = (cnt_q == FULL_CNT);
  assign empty_o   = (cnt_q == {(AW + 1){1'b0}});
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign rdata_o   = mem_q[rptr_q];
  assign count_o   = cnt_q;

  // Pointer/count next state; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push_s) begin
      wptr_d = wptr_q + AW'(1);
      cnt_d  = cnt_q + (AW + 1)'(1);
    end else if (do_pop_s) begin
      rptr_d = rptr_q + AW'(1);
      cnt_d  = cnt_q - (AW + 1)'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= {AW{1'b0}};
      rptr_q <= {AW{1'b0}};
      cnt_q  <= {(AW + 1){1'b0}};
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/qed_consistency_checker.sv
// Compares each duplicate writeback against the oldest buffered original and latches the
// first failure. Optional head-entry timeout is enabled by defining QED_CHECK_TIMEOUT_EN.
module qed_consistency_checker #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DUP_OFFSET = qed_pkg::DUP_OFFSET,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   ena_i,
  input  logic                   wb_vld_i,
  input  logic [4:0]             wb_rd_i,
  input  logic [XLEN-1:0]        wb_data_i,
  input  logic                   end_check_i,
  output logic                   check_vld_o,
  output logic                   qed_pass_o,
  output logic                   qed_error_o,
  output logic [2:0]             err_code_o,
  output logic [4:0]             err_rd_o,
  output logic [XLEN-1:0]        err_orig_data_o,
  output logic [XLEN-1:0]        err_dup_data_o,
  output logic [$clog2(DEPTH):0] pending_cnt_o
);

  import qed_pkg::*;

  localparam int unsigned EW     = 5 + XLEN;
  localparam logic [4:0]  OFF_RD = 5'(DUP_OFFSET);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_e          state_q, state_d;
  logic            wb_act_s, is_orig_s, is_dup_s, push_s, pop_s, timeout_s;
  logic            fifo_full_s, fifo_empty_s;
  logic [EW-1:0]   head_s;
  logic [4:0]      head_rd_s;
  logic [XLEN-1:0] head_data_s;
  logic            err_det_s;
  logic [2:0]      err_code_s;
  logic [4:0]      err_rd_s;
  logic [XLEN-1:0] err_orig_s, err_dup_s;
  logic            check_vld_q, check_vld_d, qed_pass_q, qed_pass_d, qed_error_q, qed_error_d;
  logic [2:0]      err_code_q, err_code_d;
  logic [4:0]      err_rd_q, err_rd_d;
  logic [XLEN-1:0] err_orig_q, err_orig_d, err_dup_q, err_dup_d;

  assign wb_act_s    = ena_i && wb_vld_i && (state_q == ST_RUN);
  assign is_orig_s   = wb_act_s && (wb_rd_i != 5'd0) && (wb_rd_i < OFF_RD);
  assign is_dup_s    = wb_act_s && (wb_rd_i >= OFF_RD);
  assign push_s      = is_orig_s && !fifo_full_s && !timeout_s;
  assign pop_s       = is_dup_s && !fifo_empty_s;
  assign head_rd_s   = head_s[EW-1:XLEN];
  assign head_data_s = head_s[XLEN-1:0];

  qed_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i ({wb_rd_i, wb_data_i}),
    .rdata_o (head_s),
    .count_o (pending_cnt_o),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

`ifdef QED_CHECK_TIMEOUT_EN
  localparam int unsigned    AGEW      = $clog2(TIMEOUT + 1);
  localparam logic [AGEW-1:0] AGE_LIMIT = AGEW'(TIMEOUT - 1);
  logic            run_ena_s;
  logic [AGEW-1:0] age_q, age_d;

  assign run_ena_s = (state_q == ST_RUN) && ena_i;
  // A same-cycle duplicate pops the head, so the compare outranks the timeout.
  assign timeout_s = run_ena_s && !fifo_empty_s && (age_q == AGE_LIMIT) && !is_dup_s;

  // Head age: restarts whenever a new entry becomes the head.
  always_comb begin
    if (pop_s || (push_s && fifo_empty_s)) begin
      age_d = {AGEW{1'b0}};
    end else if (run_ena_s && !fifo_empty_s && (age_q != AGE_LIMIT)) begin
      age_d = age_q + AGEW'(1);
    end else begin
      age_d = age_q;
    end
  end

  // Head age register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      age_q <= {AGEW{1'b0}};
    end else begin
      age_q <= age_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Failure classification for this cycle, in priority order.
  always_comb begin
    err_det_s  = 1'b0;
    err_code_s = ERR_NONE;
    err_rd_s   = 5'd0;
    err_orig_s = {XLEN{1'b0}};
    err_dup_s  = {XLEN{1'b0}};
    if (pop_s) begin
      err_rd_s   = head_rd_s;
      err_orig_s = head_data_s;
      err_dup_s  = wb_data_i;
      if (5'(head_rd_s + OFF_RD) != wb_rd_i) begin
        err_det_s  = 1'b1;
        err_code_s = ERR_RD;
      end else if (head_data_s != wb_data_i) begin
        err_det_s  = 1'b1;
        err_code_s = ERR_DATA;
      end else begin
        err_det_s  = 1'b0;
      end
    end else if (is_dup_s) begin
      err_det_s  = 1'b1;
      err_code_s = ERR_ORPHAN;
      err_rd_s   = wb_rd_i;
      err_dup_s  = wb_data_i;
    end else if (timeout_s) begin
      err_det_s  = 1'b1;
      err_code_s = ERR_TIMEOUT;
      err_rd_s   = head_rd_s;
      err_orig_s = head_data_s;
    end else if (is_orig_s && fifo_full_s) begin
      err_det_s  = 1'b1;
      err_code_s = ERR_OVF;
      err_rd_s   = wb_rd_i;
    end else begin
      err_det_s  = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: FAIL is absorbing until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (err_det_s) begin
          state_d = ST_FAIL;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_FAIL;
    endcase
  end

  // FSM outputs: pulses plus first-failure capture.
  always_comb begin
    check_vld_d = pop_s;
    qed_pass_d  = (state_q == ST_RUN) && end_check_i && fifo_empty_s && !(ena_i && wb_vld_i);
    if ((state_q == ST_RUN) && err_det_s) begin
      qed_error_d = 1'b1;
      err_code_d  = err_code_s;
      err_rd_d    = err_rd_s;
      err_orig_d  = err_orig_s;
      err_dup_d   = err_dup_s;
    end else begin
      qed_error_d = qed_error_q;
      err_code_d  = err_code_q;
      err_rd_d    = err_rd_q;
      err_orig_d  = err_orig_q;
      err_dup_d   = err_dup_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      check_vld_q <= 1'b0;
      qed_pass_q  <= 1'b0;
      qed_error_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_rd_q    <= 5'd0;
      err_orig_q  <= {XLEN{1'b0}};
      err_dup_q   <= {XLEN{1'b0}};
    end else begin
      check_vld_q <= check_vld_d;
      qed_pass_q  <= qed_pass_d;
      qed_error_q <= qed_error_d;
      err_code_q  <= err_code_d;
      err_rd_q    <= err_rd_d;
      err_orig_q  <= err_orig_d;
      err_dup_q   <= err_dup_d;
    end
  end

  assign check_vld_o     = check_vld_q;
  assign qed_pass_o      = qed_pass_q;
  assign qed_error_o     = qed_error_q;
  assign err_code_o      = err_code_q;
  assign err_rd_o        = err_rd_q;
  assign err_orig_data_o = err_orig_q;
  assign err_dup_data_o  = err_dup_q;

endmodule

// File: tb/tb_qed_consistency_checker.sv
// Scoreboard bench for qed_consistency_checker: a queue-based reference model predicts
// compare/pass/error events which a separate monitor pops as the DUT presents them.
module tb_qed_consistency_checker;

  localparam int DEPTH   = 16;
  localparam int XLEN    = 32;
  localparam int DUP     = 16;
  localparam int TIMEOUT = 8;
  localparam int EV_CHECK = 0;
  localparam int EV_ERR   = 1;
  localparam int EV_PASS  = 2;

  logic            clk, rst_ni, ena, wb_vld, end_check;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            check_vld, qed_pass, qed_error;
  logic [2:0]      err_code;
  logic [4:0]      err_rd;
  logic [XLEN-1:0] err_orig, err_dup;
  logic [4:0]      pending_cnt;

  qed_consistency_checker #(
    .DEPTH(DEPTH), .XLEN(XLEN), .DUP_OFFSET(DUP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .ena_i(ena), .wb_vld_i(wb_vld), .wb_rd_i(wb_rd),
    .wb_data_i(wb_data), .end_check_i(end_check), .check_vld_o(check_vld),
    .qed_pass_o(qed_pass), .qed_error_o(qed_error), .err_code_o(err_code),
    .err_rd_o(err_rd), .err_orig_data_o(err_orig), .err_dup_data_o(err_dup),
    .pending_cnt_o(pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int kind; int cnt; int code; int rd; logic [31:0] orig; logic [31:0] dup; } ev_t;
  typedef struct { int rd; logic [31:0] data; } ent_t;

  ev_t  expq[$];
  ent_t mq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   m_fail;
  int   m_age, m_code, m_rd;
  logic [31:0] m_orig, m_dup;
  bit   err_seen = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: what the next clock edge must produce for the given inputs.
  task automatic model_step(input bit en, input bit vld, input int rd, input logic [31:0] data,
                            input bit endc);
    bit act, is_dup, is_orig, was_empty, was_fail, tmo, popped, pass, chk_ev, err_ev;
    ent_t h;
    ev_t e;
    was_fail  = m_fail;
    was_empty = (mq.size() == 0);
    act       = en && vld && !m_fail;
    is_dup    = act && rd >= DUP;
    is_orig   = act && rd != 0 && rd < DUP;
    tmo       = 1'b0;
`ifdef QED_CHECK_TIMEOUT_EN
    tmo = !m_fail && en && !was_empty && m_age >= TIMEOUT - 1 && !is_dup;
`endif
    pass   = !m_fail && endc && was_empty && !(en && vld);
    popped = 1'b0;
    chk_ev = 1'b0;
    err_ev = 1'b0;
    if (is_dup && !was_empty) begin
      h = mq.pop_front();
      popped = 1'b1;
      chk_ev = 1'b1;
      if ((h.rd + DUP) % 32 != rd) begin
        err_ev = 1'b1; m_code = 2; m_rd = h.rd; m_orig = h.data; m_dup = data;
      end else if (h.data != data) begin
        err_ev = 1'b1; m_code = 1; m_rd = h.rd; m_orig = h.data; m_dup = data;
      end
    end else if (is_dup) begin
      err_ev = 1'b1; m_code = 3; m_rd = rd; m_orig = 0; m_dup = data;
    end else if (tmo) begin
      err_ev = 1'b1; m_code = 5; m_rd = mq[0].rd; m_orig = mq[0].data; m_dup = 0;
    end else if (is_orig && mq.size() == DEPTH) begin
      err_ev = 1'b1; m_code = 4; m_rd = rd; m_orig = 0; m_dup = 0;
    end else if (is_orig) begin
      h.rd = rd; h.data = data;
      mq.push_back(h);
    end
    if (popped || (is_orig && was_empty)) m_age = 0;
    else if (!was_fail && en && !was_empty) m_age++;
    if (err_ev) m_fail = 1'b1;
    if (chk_ev) begin e.kind = EV_CHECK; e.cnt = mq.size(); expq.push_back(e); end
    if (err_ev) begin
      e.kind = EV_ERR; e.cnt = mq.size(); e.code = m_code; e.rd = m_rd;
      e.orig = m_orig; e.dup = m_dup;
      expq.push_back(e);
    end
    if (pass) begin e.kind = EV_PASS; e.cnt = mq.size(); expq.push_back(e); end
  endtask

  task automatic cyc(input bit en, input bit vld, input int rd, input logic [31:0] data,
                     input bit endc);
    @(negedge clk);
    ena = en; wb_vld = vld; wb_rd = 5'(rd); wb_data = data; end_check = endc;
    model_step(en, vld, rd, data, endc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0, 32'h0, 1'b0);
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_check_vld"}, 64'(check_vld), 64'd0);
    chk({tag, "_qed_pass"}, 64'(qed_pass), 64'd0);
    chk({tag, "_qed_error"}, 64'(qed_error), 64'd0);
    chk({tag, "_err_code"}, 64'(err_code), 64'd0);
    chk({tag, "_err_rd"}, 64'(err_rd), 64'd0);
    chk({tag, "_err_orig"}, 64'(err_orig), 64'd0);
    chk({tag, "_err_dup"}, 64'(err_dup), 64'd0);
    chk({tag, "_pending"}, 64'(pending_cnt), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    wb_vld = 1'b0; end_check = 1'b0; ena = 1'b1;
    #2 rst_ni = 1'b0;
    #1 outputs_zero(tag);
    chk({tag, "_unconsumed_events"}, 64'(expq.size()), 64'd0);
    expq.delete(); mq.delete();
    m_fail = 1'b0; m_age = 0; m_code = 0; m_rd = 0; m_orig = 0; m_dup = 0;
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic phase_end(input string tag);
    idle(2);
    sample();
    chk({tag, "_qed_error"}, 64'(qed_error), 64'(m_fail));
    chk({tag, "_err_code"}, 64'(err_code), 64'(m_code));
    chk({tag, "_err_rd"}, 64'(err_rd), 64'(m_rd));
    chk({tag, "_err_orig"}, 64'(err_orig), 64'(m_orig));
    chk({tag, "_err_dup"}, 64'(err_dup), 64'(m_dup));
    chk({tag, "_pending"}, 64'(pending_cnt), 64'(mq.size()));
    chk({tag, "_missing_events"}, 64'(expq.size()), 64'd0);
  endtask

  task automatic pop_cmp(input int kind);
    ev_t e;
    if (expq.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL unexpected_event: got kind %0d expected none", kind);
    end else begin
      e = expq.pop_front();
      chk("event_kind", 64'(kind), 64'(e.kind));
      chk("event_pending", 64'(pending_cnt), 64'(e.cnt));
      if (e.kind == EV_ERR && kind == EV_ERR) begin
        chk("ev_err_code", 64'(err_code), 64'(e.code));
        chk("ev_err_rd", 64'(err_rd), 64'(e.rd));
        chk("ev_err_orig", 64'(err_orig), 64'(e.orig));
        chk("ev_err_dup", 64'(err_dup), 64'(e.dup));
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    forever begin
      sample();
      if (!rst_ni) begin
        err_seen = 1'b0;
      end else begin
        if (check_vld) pop_cmp(EV_CHECK);
        if (qed_error && !err_seen) begin
          err_seen = 1'b1;
          pop_cmp(EV_ERR);
        end
        if (qed_pass) pop_cmp(EV_PASS);
      end
    end
  end

  task automatic rand_round(input int n);
    int r, rd;
    bit en, v, ec;
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      r  = $urandom_range(0, 99);
      en = ($urandom_range(0, 9) != 0);
      v  = 1'b1; ec = 1'b0; rd = 0; d = $urandom;
      if (r < 15) begin
        v = 1'b0; ec = ($urandom_range(0, 2) == 0);
      end else if (r < 50) begin
        rd = $urandom_range(1, 15); d = d & 32'hFF;
      end else if (r < 88) begin
        if (mq.size() > 0) begin rd = mq[0].rd + DUP; d = mq[0].data; end
        else rd = $urandom_range(16, 31);
        if ($urandom_range(0, 24) == 0) d = d ^ (32'h1 << $urandom_range(0, 31));
        if ($urandom_range(0, 29) == 0) rd = rd ^ 1;
      end else begin
        rd = $urandom_range(0, 31);
      end
      cyc(en, v, rd, d, ec);
    end
  endtask

  initial begin
    rst_ni = 1'b0; ena = 1'b0; wb_vld = 1'b0; wb_rd = 5'd0; wb_data = 32'h0; end_check = 1'b0;
    m_fail = 1'b0; m_age = 0; m_code = 0; m_rd = 0; m_orig = 0; m_dup = 0;
    #12 outputs_zero("por");
    @(negedge clk);
    rst_ni = 1'b1;

    // matched pair then drain check
    cyc(1, 1, 3, 32'hAA, 0);
    sample(); chk("pair_pending_1", 64'(pending_cnt), 64'd1);
    cyc(1, 1, 19, 32'hAA, 0);
    sample(); chk("pair_check_vld", 64'(check_vld), 64'd1);
    chk("pair_pending_0", 64'(pending_cnt), 64'd0);
    cyc(1, 0, 0, 32'h0, 1);
    sample(); chk("pair_qed_pass", 64'(qed_pass), 64'd1);
    phase_end("pair");
    chk("pair_no_error", 64'(qed_error), 64'd0);

    // data mismatch, later pair must not disturb the captured failure
    do_reset("rst_dm");
    cyc(1, 1, 5, 32'h1234, 0);
    cyc(1, 1, 21, 32'h1235, 0);
    cyc(1, 1, 6, 32'h55, 0);
    cyc(1, 1, 22, 32'h66, 0);
    cyc(1, 0, 0, 32'h0, 1);
    phase_end("dm");
    chk("dm_code", 64'(err_code), 64'd1);
    chk("dm_rd", 64'(err_rd), 64'd5);
    chk("dm_orig", 64'(err_orig), 64'h1234);
    chk("dm_dup", 64'(err_dup), 64'h1235);

    // ordering
    do_reset("rst_ord");
    for (int i = 1; i <= 3; i++) cyc(1, 1, i, 32'h100 + i, 0);
    for (int i = 1; i <= 3; i++) cyc(1, 1, i + 16, 32'h100 + i, 0);
    phase_end("ord");
    chk("ord_no_error", 64'(qed_error), 64'd0);
    do_reset("rst_ord2");
    for (int i = 1; i <= 3; i++) cyc(1, 1, i, 32'h100 + i, 0);
    cyc(1, 1, 18, 32'h102, 0);
    phase_end("ord2");
    chk("ord2_code", 64'(err_code), 64'd2);
    chk("ord2_rd", 64'(err_rd), 64'd1);

    // orphan duplicate, ena-low duplicate ignored first
    do_reset("rst_orph");
    cyc(0, 1, 20, 32'h9, 0);
    cyc(1, 1, 20, 32'h7, 0);
    phase_end("orph");
    chk("orph_code", 64'(err_code), 64'd3);
    chk("orph_rd", 64'(err_rd), 64'd20);
    chk("orph_dup", 64'(err_dup), 64'h7);

    // overflow, then asynchronous reset mid-stream
    do_reset("rst_ovf");
    for (int i = 0; i < 17; i++) cyc(1, 1, (i % 15) + 1, 32'h200 + i, 0);
    phase_end("ovf");
`ifndef QED_CHECK_TIMEOUT_EN
    chk("ovf_code", 64'(err_code), 64'd4);
    chk("ovf_pending", 64'(pending_cnt), 64'd16);
`endif
    do_reset("rst_async");

    // head timeout
    cyc(1, 1, 4, 32'h44, 0);
`ifdef QED_CHECK_TIMEOUT_EN
    idle(7);
    sample(); chk("to_before", 64'(qed_error), 64'd0);
    idle(1);
    sample(); chk("to_at", 64'(qed_error), 64'd1);
    chk("to_code", 64'(err_code), 64'd5);
    chk("to_rd", 64'(err_rd), 64'd4);
`else
    idle(20);
    sample(); chk("to_none", 64'(qed_error), 64'd0);
`endif
    phase_end("to");

    for (int k = 0; k < 6; k++) begin
      do_reset("rst_rand");
      rand_round(250);
      phase_end("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
